lif_synapse_accumulator: RTL and testbench
==========================================

Name: lif_synapse_accumulator

Overview:
Upstream synaptic stage for the leaky integrate-and-fire neuron. It stores one signed weight per input synapse and latches an input spike vector on each timestep tick. It then serially accumulates the weights of the active synapses, one synapse per cycle. The saturated input current is delivered to the neuron stage over a valid/ready handshake.

Parameters:
N_SYN, 8, number of input synapses (power of 2, >=2)
W_WIDTH, 8, signed weight width
ACC_WIDTH, 12, signed accumulator width; must be >= W_WIDTH+log2(N_SYN)+1
OUT_WIDTH, 8, signed width of current delivered to the neuron

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
ena  input  1  stage enable; when low, all state holds and writes are ignored
spikes_in  input  N_SYN  input spike vector; sampled only on an accepted tick
tick  input  1  timestep strobe, one-cycle pulse
wr_en  input  1  weight write strobe
wr_addr  input  log2(N_SYN)  weight index
wr_data  input  W_WIDTH  signed weight value
cur_out  output  OUT_WIDTH  signed saturated current
cur_valid  output  1  cur_out valid
cur_ready  input  1  neuron stage accepts current
sat  output  1  cur_out was clamped; qualified by cur_valid
busy  output  1  high in ACCUM or OUT
tick_drop  output  1  one-cycle pulse when a tick is rejected

Behaviour:
- Reset (rst_n low at edge):
  - all weights 0; state IDLE; idx 0; acc 0
  - cur_out 0, cur_valid 0, sat 0, busy 0, tick_drop 0
  - Reset overrides all other inputs, including in mid-ACCUM or OUT; pending result discarded.
- ena low: every register holds (state, idx, acc, outputs, weights); tick and wr_en ignored; tick_drop 0.
- States are IDLE, ACCUM and OUT:
  - IDLE: on tick, latch spikes_in into snap, set acc=0 and idx=0, go to ACCUM.
  - ACCUM: each cycle, if snap[idx] then acc <= acc + sign-extended w[idx]. Then idx <= idx+1. On idx==N_SYN-1, go to OUT, load cur_out=clamp(final acc) and sat, and set cur_valid=1.
  - OUT: cur_out, sat and cur_valid are held stable while cur_ready=0. On the cur_valid&&cur_ready edge:
    - if tick is also high: start a new accumulation directly (latch spikes_in, acc=0, idx=0, go to ACCUM, cur_valid=0);
    - otherwise: go to IDLE, cur_valid=0.
- Latency: a tick accepted at edge t gives cur_valid high after edge t+N_SYN (N_SYN cycles in ACCUM). Throughput is one result per N_SYN+1 cycles with cur_ready held high.
- Rejected ticks:
  - A tick in ACCUM, or in OUT without a same-cycle handshake, is dropped. tick_drop pulses high for exactly one cycle and state is unaffected.
- Weight writes:
  - Accepted in any state when ena=1; w[wr_addr] <= wr_data.
  - ACCUM reads the weight register value present before the edge. A write to index idx in the same cycle that idx is accumulated uses the old value.
  - A write to an index not yet processed affects the current sum.
- Arithmetic:
  - Two's complement throughout; acc never wraps, given the ACC_WIDTH rule.
  - clamp: acc > 2^(OUT_WIDTH-1)-1 gives max with sat=1; acc < -2^(OUT_WIDTH-1) gives min with sat=1; otherwise cur_out=acc[OUT_WIDTH-1:0] with sat=0.
- busy = (state != IDLE).
- cur_out keeps its last value after a handshake; it is not cleared.

Test Plan:
1. Reset, ena=1, tick with spikes_in=0xFF and all weights 0 -> cur_valid high 8 cycles later; cur_out=0, sat=0.
2. Write w0=10, w1=-3, w7=100; tick with spikes_in=0x83, cur_ready=1 -> cur_out=107, sat=0, cur_valid for exactly 1 cycle, then IDLE with busy=0.
3. All weights 100, spikes_in=0xFF -> acc=800, cur_out=127, sat=1. All weights -100 -> cur_out=-128, sat=1. spikes_in=0x00 -> cur_out=0.
4. cur_ready low for 5 cycles in OUT -> cur_out and cur_valid stable; a tick mid-wait gives a one-cycle tick_drop pulse and no new result. A tick coincident with the handshake -> new result 8 cycles later, no tick_drop.
5. rst_n low at ACCUM idx=4 -> next cycle IDLE, busy=0, cur_valid=0; a re-tick with spikes_in=0xFF -> cur_out=0 (weights cleared).
6. ena low for 3 cycles during ACCUM -> cur_valid delayed by exactly 3 cycles, same value. Write w2=50 while ACCUM is at idx=1 (spike 2 set, weight previously 0) -> result includes 50.

Source files
------------

// File: rtl/lif_synapse_accumulator_if.sv
// Handshake and configuration bundle between the synapse accumulator and its
// neighbours: spike/tick input, weight-write port and the current output.
interface lif_synapse_accumulator_if #(
  parameter int N_SYN     = 8,
  parameter int W_WIDTH   = 8,
  parameter int OUT_WIDTH = 8
);
  localparam int AW = $clog2(N_SYN);

  logic                 ena;
  logic [N_SYN-1:0]     spikes_in;
  logic                 tick;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [W_WIDTH-1:0]   wr_data;
  logic [OUT_WIDTH-1:0] cur_out;
  logic                 cur_valid;
  logic                 cur_ready;
  logic                 sat;
  logic                 busy;
  logic                 tick_drop;

  modport master (
    output ena, spikes_in, tick, wr_en, wr_addr, wr_data, cur_ready,
    input  cur_out, cur_valid, sat, busy, tick_drop
  );

  modport slave (
    input  ena, spikes_in, tick, wr_en, wr_addr, wr_data, cur_ready,
    output cur_out, cur_valid, sat, busy, tick_drop
  );
endinterface

// File: rtl/lif_synapse_accumulator.sv
// Synaptic input stage for the LIF neuron: per-synapse signed weights, spike
// snapshot on tick, serial weighted sum (one synapse per cycle), saturated
// current handed to the neuron over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a tick
// S_ACCUM | adding w[idx] for each set snapshot bit, idx 0..N_SYN-1
// S_OUT   | cur_out/sat held with cur_valid high until cur_ready
module lif_synapse_accumulator #(
  parameter int N_SYN     = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 12,
  parameter int OUT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  lif_synapse_accumulator_if.slave bus
);
  localparam int AW = $clog2(N_SYN);
  localparam logic [AW-1:0] IDX_LAST = AW'(N_SYN - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [N_SYN-1:0]             snap_q, snap_d;
  logic [W_WIDTH-1:0]           w_q [N_SYN];
  logic [W_WIDTH-1:0]           w_d [N_SYN];
  logic [OUT_WIDTH-1:0]         cur_out_q, cur_out_d;
  logic                         cur_valid_q, cur_valid_d;
  logic                         sat_q, sat_d;
  logic                         tick_drop_q, tick_drop_d;

  logic signed [ACC_WIDTH-1:0]  addend;
  logic signed [ACC_WIDTH-1:0]  acc_sum;

  // Contribution of the synapse at idx; weights are read before any same-edge write.
  always_comb begin
    addend = '0;
    if (snap_q[idx_q]) begin
      addend = {{(ACC_WIDTH - W_WIDTH){w_q[idx_q][W_WIDTH-1]}}, w_q[idx_q]};
    end
    acc_sum = acc_q + addend;
  end

  // Next-state logic for the sequencer, weight file and output registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    snap_d      = snap_q;
    w_d         = w_q;
    cur_out_d   = cur_out_q;
    cur_valid_d = cur_valid_q;
    sat_d       = sat_q;
    tick_drop_d = 1'b0;

    if (bus.ena) begin
      if (bus.wr_en) begin
        w_d[bus.wr_addr] = bus.wr_data;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.tick) begin
            snap_d  = bus.spikes_in;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_ACCUM;
          end
        end

        S_ACCUM: begin
          acc_d = acc_sum;
          idx_d = idx_q + 1'b1;
          if (bus.tick) begin
            tick_drop_d = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d     = S_OUT;
            cur_valid_d = 1'b1;
            if (acc_sum > OUT_MAX) begin
              cur_out_d = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
              sat_d     = 1'b1;
            end else if (acc_sum < OUT_MIN) begin
              cur_out_d = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
              sat_d     = 1'b1;
            end else begin
              cur_out_d = acc_sum[OUT_WIDTH-1:0];
              sat_d     = 1'b0;
            end
          end
        end

        S_OUT: begin
          if (bus.cur_ready) begin
            cur_valid_d = 1'b0;
            if (bus.tick) begin
              snap_d  = bus.spikes_in;
              acc_d   = '0;
              idx_d   = '0;
              state_d = S_ACCUM;
            end else begin
              state_d = S_IDLE;
            end
          end else if (bus.tick) begin
            tick_drop_d = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      snap_q      <= '0;
      for (int i = 0; i < N_SYN; i++) begin
        w_q[i] <= '0;
      end
      cur_out_q   <= '0;
      cur_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      tick_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      snap_q      <= snap_d;
      w_q         <= w_d;
      cur_out_q   <= cur_out_d;
      cur_valid_q <= cur_valid_d;
      sat_q       <= sat_d;
      tick_drop_q <= tick_drop_d;
    end
  end

  assign bus.cur_out   = cur_out_q;
  assign bus.cur_valid = cur_valid_q;
  assign bus.sat       = sat_q;
  assign bus.tick_drop = tick_drop_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lif_synapse_accumulator.sv
// Bench for lif_synapse_accumulator: directed vectors, expected currents
// queued at stimulus time and checked by an independent output monitor.
module tb_lif_synapse_accumulator;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [7:0] out;
    logic       sat;
  } exp_t;
  exp_t exp_q[$];

  lif_synapse_accumulator_if #(.N_SYN(N), .W_WIDTH(8), .OUT_WIDTH(8)) bus ();

  lif_synapse_accumulator #(.N_SYN(N), .W_WIDTH(8), .ACC_WIDTH(12), .OUT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Monitor: every accepted output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.ena && bus.cur_valid && bus.cur_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got cur_out=%0d sat=%0b expected no result",
                 $signed(bus.cur_out), bus.sat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.cur_out !== e.out || bus.sat !== e.sat) begin
          failures++;
          $display("FAIL result: got cur_out=%0d sat=%0b expected cur_out=%0d sat=%0b",
                   $signed(bus.cur_out), bus.sat, $signed(e.out), e.sat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int idx, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_addr = idx[2:0];
    bus.wr_data = val[7:0];
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic issue(input logic [7:0] spk, input int exp_val, input logic exp_sat);
    exp_t e;
    e.out = exp_val[7:0];
    e.sat = exp_sat;
    exp_q.push_back(e);
    bus.spikes_in = spk;
    bus.tick      = 1'b1;
    step();
    bus.tick      = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int already, input int exp_lat);
    int n;
    n = already;
    while (!bus.cur_valid && n < 100) begin
      step();
      n++;
    end
    check(name, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.spikes_in = '0;
    bus.tick      = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.cur_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    check("rst_cur_valid", bus.cur_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cur_out", bus.cur_out, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_tick_drop", bus.tick_drop, 0);

    // 1: zero weights, all spikes
    issue(8'hFF, 0, 1'b0);
    check("t1_busy", bus.busy, 1);
    wait_valid("t1_latency", 0, N);
    step();

    // 2: sparse weights, one-cycle valid then idle
    write_w(0, 10);
    write_w(1, -3);
    write_w(7, 100);
    issue(8'h83, 107, 1'b0);
    wait_valid("t2_latency", 0, N);
    check("t2_valid_high", bus.cur_valid, 1);
    step();
    check("t2_valid_one_cycle", bus.cur_valid, 0);
    check("t2_idle_busy", bus.busy, 0);

    // 3: saturation both ways and empty spike vector
    for (int i = 0; i < N; i++) write_w(i, 100);
    issue(8'hFF, 127, 1'b1);
    wait_valid("t3_pos_latency", 0, N);
    step();
    for (int i = 0; i < N; i++) write_w(i, -100);
    issue(8'hFF, -128, 1'b1);
    wait_valid("t3_neg_latency", 0, N);
    step();
    issue(8'h00, 0, 1'b0);
    wait_valid("t3_zero_latency", 0, N);
    step();

    // 4: back-pressure, dropped tick, tick coincident with handshake
    bus.cur_ready = 1'b0;
    issue(8'h01, -100, 1'b0);
    wait_valid("t4_latency", 0, N);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", bus.cur_valid, 1);
      check("t4_hold_out", $signed(bus.cur_out), -100);
      check("t4_tick_drop", bus.tick_drop, (i == 2) ? 1 : 0);
      if (i == 1) begin
        bus.spikes_in = 8'hFF;
        bus.tick      = 1'b1;
      end
      step();
      bus.tick = 1'b0;
    end
    bus.cur_ready = 1'b1;
    issue(8'h03, -128, 1'b1);
    check("t4_no_drop_on_hs", bus.tick_drop, 0);
    check("t4_valid_cleared", bus.cur_valid, 0);
    check("t4_busy_restart", bus.busy, 1);
    wait_valid("t4_b2b_latency", 0, N);
    step();
    check("t4_idle", bus.busy, 0);

    // 5: reset mid-accumulation clears weights and discards result
    bus.spikes_in = 8'hFF;
    bus.tick      = 1'b1;
    step();
    bus.tick = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t5_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    step();
    check("t5_busy_after_rst", bus.busy, 0);
    check("t5_valid_after_rst", bus.cur_valid, 0);
    rst_n = 1'b1;
    issue(8'hFF, 0, 1'b0);
    wait_valid("t5_latency", 0, N);
    step();

    // 6: enable stall, in-flight write ahead of idx, ignored write while disabled
    write_w(0, 5);
    write_w(3, 20);
    issue(8'h1F, 75, 1'b0);
    lat = 0;
    step();
    lat++;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 8'd50;
    step();
    lat++;
    bus.wr_en = 1'b0;
    step();
    lat++;
    bus.ena       = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd4;
    bus.wr_data   = 8'd30;
    bus.tick      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      lat++;
      check("t6_no_drop_disabled", bus.tick_drop, 0);
    end
    bus.ena   = 1'b1;
    bus.wr_en = 1'b0;
    bus.tick  = 1'b0;
    wait_valid("t6_stall_latency", lat, N + 3);
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
